// File: rtl/perf_counter_ctrl.sv
// Avalon-MM controlled cycle counter with prescaler, compare match, wrap event and snapshot.
// count_out feeds the HPS PIO input port directly.
module perf_counter_ctrl #(
    parameter int unsigned COUNT_W    = 32,
    parameter int unsigned PRESCALE_W = 16,
    parameter bit          RESET_RUN  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               read,
    input  logic               write,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic               irq,
    output logic [COUNT_W-1:0] count_out
);

    localparam logic [COUNT_W-1:0] CountOnes = {COUNT_W{1'b1}};

    logic                  run_q, run_d;
    logic                  irq_en_q, irq_en_d;
    logic                  auto_reload_q, auto_reload_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] div_q, div_d;
    logic [COUNT_W-1:0]    compare_q, compare_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [COUNT_W-1:0]    snapshot_q, snapshot_d;
    logic                  match_q, match_d;
    logic                  ovf_q, ovf_d;
    logic [31:0]           readdata_q, readdata_d;
    logic                  irq_q, irq_d;

    logic               wr_en, rd_en, clear, tick, set_match, set_ovf;
    logic [COUNT_W-1:0] count_next;

    assign wr_en      = chipselect & write;
    assign rd_en      = chipselect & read;
    assign clear      = wr_en && (address == 3'd0) && writedata[3];
    assign tick       = run_q && (div_q == prescale_q);
    assign count_next = count_q + 1'b1;

    always_comb begin
        run_d         = run_q;
        irq_en_d      = irq_en_q;
        auto_reload_d = auto_reload_q;
        prescale_d    = prescale_q;
        compare_d     = compare_q;
        snapshot_d    = snapshot_q;
        div_d         = div_q;
        count_d       = count_q;
        set_match     = 1'b0;
        set_ovf       = 1'b0;
        readdata_d    = readdata_q;

        // Divider freezes (not clears) while stopped.
        if (run_q) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end
        if (clear || (wr_en && address == 3'd1)) begin
            div_d = '0;
        end

        if (clear) begin
            count_d = '0;
        end else if (wr_en && address == 3'd3) begin
            count_d = writedata[COUNT_W-1:0];
        end else if (tick) begin
            if (count_next == compare_q) begin
                set_match = 1'b1;
                if (auto_reload_q) begin
                    count_d = '0;
                    set_ovf = (count_q == CountOnes);
                end else begin
                    count_d = count_next;
                end
            end else if (count_q == CountOnes) begin
                count_d = '0;
                set_ovf = 1'b1;
            end else begin
                count_d = count_next;
            end
        end

        if (wr_en) begin
            unique case (address)
                3'd0: begin
                    run_d         = writedata[0];
                    irq_en_d      = writedata[1];
                    auto_reload_d = writedata[2];
                end
                3'd1: prescale_d = writedata[PRESCALE_W-1:0];
                3'd2: compare_d  = writedata[COUNT_W-1:0];
                3'd4: snapshot_d = count_q;
                default: ;
            endcase
        end

        // A hardware set beats a simultaneous W1C.
        match_d = (match_q & ~(wr_en && address == 3'd5 && writedata[0])) | set_match;
        ovf_d   = (ovf_q & ~(wr_en && address == 3'd5 && writedata[1])) | set_ovf;
        irq_d   = irq_en_d & (match_d | ovf_d);

        if (rd_en) begin
            unique case (address)
                3'd0:    readdata_d = {29'd0, auto_reload_q, irq_en_q, run_q};
                3'd1:    readdata_d = 32'(prescale_q);
                3'd2:    readdata_d = 32'(compare_q);
                3'd3:    readdata_d = 32'(count_q);
                3'd4:    readdata_d = 32'(snapshot_q);
                3'd5:    readdata_d = {29'd0, run_q, ovf_q, match_q};
                default: readdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q         <= RESET_RUN;
            irq_en_q      <= 1'b0;
            auto_reload_q <= 1'b0;
            prescale_q    <= '0;
            div_q         <= '0;
            compare_q     <= CountOnes;
            count_q       <= '0;
            snapshot_q    <= '0;
            match_q       <= 1'b0;
            ovf_q         <= 1'b0;
            readdata_q    <= 32'd0;
            irq_q         <= 1'b0;
        end else begin
            run_q         <= run_d;
            irq_en_q      <= irq_en_d;
            auto_reload_q <= auto_reload_d;
            prescale_q    <= prescale_d;
            div_q         <= div_d;
            compare_q     <= compare_d;
            count_q       <= count_d;
            snapshot_q    <= snapshot_d;
            match_q       <= match_d;
            ovf_q         <= ovf_d;
            readdata_q    <= readdata_d;
            irq_q         <= irq_d;
        end
    end

    assign readdata  = readdata_q;
    assign irq       = irq_q;
    assign count_out = count_q;

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Self-checking bench for perf_counter_ctrl: directed scenarios plus random bus traffic
// checked against a cycle-level behavioural model of the register map.
module tb_perf_counter_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect, read, write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [31:0] count_out;

    int n_chk  = 0;
    int n_fail = 0;

    perf_counter_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .count_out  (count_out)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit          m_run, m_ien, m_ar, m_match, m_ovf, m_irq;
    int unsigned m_pre, m_div;
    logic [31:0] m_cmp, m_cnt, m_snap, m_rd;

    task automatic model_clock();
        logic [31:0] rv, nxt, new_cnt;
        bit          tick, clr, wen, ren, sm, so;
        if (reset) begin
            m_run = 0; m_ien = 0; m_ar = 0; m_match = 0; m_ovf = 0; m_irq = 0;
            m_pre = 0; m_div = 0; m_cmp = 32'hFFFF_FFFF; m_cnt = 0; m_snap = 0; m_rd = 0;
            return;
        end
        wen = chipselect && write;
        ren = chipselect && read;
        case (address)
            3'd0: rv = {29'd0, m_ar, m_ien, m_run};
            3'd1: rv = m_pre;
            3'd2: rv = m_cmp;
            3'd3: rv = m_cnt;
            3'd4: rv = m_snap;
            3'd5: rv = {29'd0, m_run, m_ovf, m_match};
            default: rv = 0;
        endcase
        if (ren) m_rd = rv;
        tick = m_run && (m_div == m_pre);
        clr  = wen && address == 0 && writedata[3];
        sm = 0; so = 0;
        nxt = m_cnt + 1;
        new_cnt = m_cnt;
        if (clr) new_cnt = 0;
        else if (wen && address == 3) new_cnt = writedata;
        else if (tick) begin
            if (nxt == m_cmp) begin
                sm = 1;
                if (m_ar) begin new_cnt = 0; so = (m_cnt == 32'hFFFF_FFFF); end
                else new_cnt = nxt;
            end else if (m_cnt == 32'hFFFF_FFFF) begin
                new_cnt = 0; so = 1;
            end else new_cnt = nxt;
        end
        if (m_run) m_div = tick ? 0 : m_div + 1;
        if (clr || (wen && address == 1)) m_div = 0;
        if (wen && address == 4) m_snap = m_cnt;
        m_cnt = new_cnt;
        if (wen && address == 0) begin
            m_run = writedata[0]; m_ien = writedata[1]; m_ar = writedata[2];
        end
        if (wen && address == 1) m_pre = writedata[15:0];
        if (wen && address == 2) m_cmp = writedata;
        if (wen && address == 5) begin
            if (writedata[0]) m_match = 0;
            if (writedata[1]) m_ovf = 0;
        end
        m_match = m_match | sm;
        m_ovf   = m_ovf | so;
        m_irq   = m_ien && (m_match || m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        chipselect = 0; read = 0; write = 0; address = 0; writedata = 0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1; write = 1; read = 0; address = a; writedata = d;
        step();
        idle();
    endtask

    task automatic bus_read(input logic [2:0] a);
        chipselect = 1; read = 1; write = 0; address = a; writedata = 0;
        step();
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] exp_rst [8];
        exp_rst = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        idle();
        reset = 1;
        step(); step();
        reset = 0;
        n_chk++;
        if (count_out !== 32'd0 || irq !== 1'b0 || readdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got cnt=%h irq=%b rd=%h required 0/0/0",
                     count_out, irq, readdata);
        end
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i));
            n_chk++;
            if (readdata !== exp_rst[i]) begin
                n_fail++;
                $display("FAIL reset_read_%0d: got %h required %h", i, readdata, exp_rst[i]);
            end
        end
    endtask

    task automatic test_prescale();
        logic [31:0] prev;
        int          changes;
        bus_write(3'd1, 32'd3);
        bus_write(3'd0, 32'h1);
        changes = 0;
        prev = count_out;
        for (int i = 0; i < 40; i++) begin
            step();
            if (count_out !== prev) changes++;
            prev = count_out;
        end
        n_chk++;
        if (count_out !== m_cnt || count_out < 9 || count_out > 11) begin
            n_fail++;
            $display("FAIL prescale_count: got %0d required %0d (~10)", count_out, m_cnt);
        end
        n_chk++;
        if (changes != 10) begin
            n_fail++;
            $display("FAIL prescale_rate: got %0d increments required 10", changes);
        end
        bus_read(3'd3);
        n_chk++;
        if (readdata !== m_rd) begin
            n_fail++;
            $display("FAIL prescale_read: got %h required %h", readdata, m_rd);
        end
    endtask

    task automatic test_auto_reload();
        logic [31:0] exp_seq [6];
        exp_seq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd1};
        bus_write(3'd1, 32'd0);
        bus_write(3'd2, 32'd5);
        bus_write(3'd0, 32'hF);
        n_chk++;
        if (count_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reload_start: got %h required 0", count_out);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            n_chk++;
            if (count_out !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL reload_seq_%0d: got %h required %h", i, count_out, exp_seq[i]);
            end
            if (i == 3 && irq !== 1'b0) begin
                n_fail++;
                $display("FAIL reload_irq_early: got %b required 0", irq);
            end
        end
        n_chk++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_irq: got %b required 1", irq);
        end
        bus_read(3'd5);
        n_chk++;
        if (readdata !== 32'h5 || readdata !== m_rd) begin
            n_fail++;
            $display("FAIL reload_status: got %h required %h", readdata, m_rd);
        end
        bus_write(3'd5, 32'h1);
        n_chk++;
        if (irq !== 1'b0 || irq !== m_irq) begin
            n_fail++;
            $display("FAIL reload_w1c_irq: got %b required 0", irq);
        end
    endtask

    task automatic test_wrap();
        bus_write(3'd0, 32'h9);
        bus_write(3'd2, 32'h100);
        bus_write(3'd5, 32'h3);
        bus_write(3'd3, 32'hFFFF_FFFE);
        n_chk++;
        if (count_out !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL wrap_preset: got %h required fffffffe", count_out);
        end
        step();
        n_chk++;
        if (count_out !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL wrap_ones: got %h required ffffffff", count_out);
        end
        step();
        n_chk++;
        if (count_out !== 32'd0) begin
            n_fail++;
            $display("FAIL wrap_zero: got %h required 0", count_out);
        end
        bus_read(3'd5);
        n_chk++;
        if (readdata !== 32'h6) begin
            n_fail++;
            $display("FAIL wrap_status: got %h required 6", readdata);
        end
        step(); step();
        bus_write(3'd0, 32'h9);
        n_chk++;
        if (count_out !== 32'd0) begin
            n_fail++;
            $display("FAIL clear_running: got %h required 0", count_out);
        end
    endtask

    task automatic test_snapshot();
        bus_write(3'd3, 32'd100);
        bus_write(3'd4, 32'd0);
        for (int i = 0; i < 49; i++) step();
        n_chk++;
        if (count_out !== 32'd150) begin
            n_fail++;
            $display("FAIL snap_count: got %0d required 150", count_out);
        end
        bus_read(3'd4);
        n_chk++;
        if (readdata !== 32'd100) begin
            n_fail++;
            $display("FAIL snap_value: got %0d required 100", readdata);
        end
        bus_read(3'd3);
        n_chk++;
        if (readdata !== m_rd) begin
            n_fail++;
            $display("FAIL snap_count_read: got %0d required %0d", readdata, m_rd);
        end
    endtask

    task automatic test_reset_midrun();
        bus_write(3'd2, 32'd3);
        bus_write(3'd0, 32'hF);
        for (int i = 0; i < 3; i++) step();
        n_chk++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL midrun_irq_pre: got %b required 1", irq);
        end
        reset = 1;
        step();
        reset = 0;
        n_chk++;
        if (count_out !== 32'd0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: got cnt=%h irq=%b required 0/0", count_out, irq);
        end
        for (int i = 0; i < 5; i++) step();
        bus_read(3'd5);
        n_chk++;
        if (readdata !== 32'd0 || count_out !== 32'd0) begin
            n_fail++;
            $display("FAIL midrun_stopped: got status=%h cnt=%h required 0/0", readdata, count_out);
        end
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 15);
            chipselect = ($urandom_range(0, 7) != 0);
            read = 0; write = 0;
            address = 3'($urandom_range(0, 7));
            writedata = $urandom;
            if (op < 4) read = 1;
            else if (op < 11) begin
                write = 1;
                case (address)
                    3'd0: writedata = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(8, 15))
                                                                  : 32'($urandom_range(0, 7));
                    3'd1: writedata = 32'($urandom_range(0, 3));
                    3'd2: writedata = ($urandom_range(0, 3) == 0) ? 32'd0
                                                                  : 32'($urandom_range(1, 30));
                    3'd3: writedata = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20))
                                      : 32'hFFFF_FFFF - 32'($urandom_range(0, 10));
                    default: ;
                endcase
            end
            step();
            n_chk++;
            if (count_out !== m_cnt || irq !== m_irq || readdata !== m_rd) begin
                n_fail++;
                $display("FAIL random_%0d: got cnt=%h irq=%b rd=%h required cnt=%h irq=%b rd=%h",
                         i, count_out, irq, readdata, m_cnt, m_irq, m_rd);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_prescale();
        test_auto_reload();
        test_wrap();
        test_snapshot();
        test_reset_midrun();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_counter_ctrl.md
Name: perf_counter_ctrl

Overview:
Avalon-MM slave that owns and sequences the free-running cycle counter. Its count is sampled by the read-only 32-bit PIO input port on the HPS lightweight bridge. The block lets the ARM start, stop, clear, preset, prescale and snapshot the counter. It also provides a compare match and a wrap (overflow) event with an interrupt, so the boid software can time frame and update loops. count_out wires directly to the PIO in_port.

Parameters:
COUNT_W, 32, counter and compare width (max 32)
PRESCALE_W, 16, prescaler register width
RESET_RUN, 0, RUN bit value after reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  3  word address of register
chipselect  in  1  slave select
read  in  1  read strobe
write  in  1  write strobe
writedata  in  32  write data
readdata  out  32  registered read data
irq  out  1  interrupt, level
count_out  out  COUNT_W  live count, to PIO in_port

Behaviour:
- Register map (word addresses):
  - 0 CONTROL (rw): b0 RUN, b1 IRQ_EN, b2 AUTO_RELOAD; b3 CLEAR is write-only, self-clearing and reads 0.
  - 1 PRESCALE (rw).
  - 2 COMPARE (rw).
  - 3 COUNT: read returns the live count; write presets it.
  - 4 SNAPSHOT: any write latches the current count; read returns the latched value.
  - 5 STATUS: b0 MATCH (sticky, W1C), b1 OVF (sticky, W1C), b2 RUNNING (ro = RUN).
  - 6 and 7: read 0, writes ignored.
- Reset values: readdata=0, irq=0, count=0, snapshot=0, PRESCALE=0, COMPARE=all ones, CONTROL=RESET_RUN in b0 with other bits 0, STATUS sticky bits=0, prescaler divider=0.
- Reset is synchronous and overrides everything, including an access in the same cycle. Reset mid-count zeroes the count with no event.
- Accesses take effect only when chipselect=1.
- Read latency is 1 cycle. readdata updates on the clock after chipselect&read and otherwise holds.
- The read mux samples pre-edge register values, so a read in the same cycle as a write returns the old value.
- Prescaler:
  - Divider counts 0..PRESCALE while RUN=1.
  - A tick is issued in the cycle the divider equals PRESCALE; the divider then returns to 0.
  - PRESCALE=0 gives a tick every clock.
  - RUN=0 freezes the divider at its current value; it is not cleared.
  - Writing PRESCALE or CLEAR zeroes the divider.
- Counter update, with priority highest first:
  1. CLEAR: count<=0; no MATCH or OVF is set.
  2. COUNT write: count<=writedata; no event is set; a tick in the same cycle is dropped.
  3. Tick: next=count+1 (mod 2^COUNT_W).
     - If next==COMPARE: set MATCH. If AUTO_RELOAD=1 also, count<=0; otherwise count<=next.
     - Else if count was all ones (wrap): count<=0 and set OVF.
     - Else count<=next.
  4. Otherwise count holds.
- With AUTO_RELOAD=1 the period is COMPARE ticks, so count sequences 0..COMPARE-1.
- COMPARE=0 with AUTO_RELOAD=1: the match occurs on wrap (next==0). Both MATCH and OVF are set, and count becomes 0.
- STATUS W1C: a hardware set in the same cycle as a W1C of the same bit wins, and the bit stays 1.
- SNAPSHOT write: latches count as it was before the edge, ignoring that cycle's update.
- count_out: equals the count register, with no extra pipeline.
- irq is registered: irq <= IRQ_EN & (MATCH|OVF), using the updated sticky bits. It asserts 1 cycle after the event cycle and deasserts 1 cycle after the clearing W1C or IRQ_EN=0.
- Writing CONTROL with RUN=0 stops ticking from the next cycle. A tick already due in the write cycle still applies.

Test Plan:
- Reset, then read all 8 addresses. Expect COUNT=0, PRESCALE=0, COMPARE=0xFFFFFFFF, STATUS=0, addresses 6/7=0, irq=0, readdata valid 1 cycle after each read.
- Write PRESCALE=3, then CONTROL=1. After 40 clocks, COUNT reads 10 (±1 for the read edge) and count_out increments every 4th clock.
- Write COMPARE=5, CONTROL=0x7 (RUN, IRQ_EN, AUTO_RELOAD), PRESCALE=0. Expect count sequence 0,1,2,3,4,0; MATCH=1; irq rises 1 clock after the reload. W1C STATUS=1, then irq falls 1 clock later.
- COUNT write 0xFFFFFFFE while running at PRESCALE=0. Expect count 0xFFFFFFFF then 0, OVF=1, MATCH=0. Repeat with CLEAR and a COUNT write in the same cycle: count=0.
- SNAPSHOT write at count=100, then run 50 more ticks. SNAPSHOT reads 100 and COUNT reads 150.
- Assert reset while running with irq high. The next cycle shows count=0, irq=0, STATUS=0, and the counter stays stopped (RESET_RUN=0).
